// File: rtl/display_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display: digit-select
// prescaler, frame-synchronous blink and one-shot message arbitration.
module display_scan_ctrl #(
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int MSG_FRAMES   = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       blink_en,
  input  logic       msg_req,
  input  logic [1:0] msg_code,
  output logic [1:0] contador,
  output logic       frame_tick,
  output logic       blank,
  output logic       msg_active,
  output logic [1:0] msg_sel,
  output logic       msg_ack,
  output logic       busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int MW = (MSG_FRAMES > 1) ? $clog2(MSG_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [MW-1:0] M_LAST = MW'(MSG_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_SHOW} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [MW-1:0] r_frame_cnt;

  logic w_slot_end;
  logic w_blink_wrap;
  logic w_phase_nxt;
  logic w_accept;
  logic w_frame_inc;
  logic w_msg_active_nxt;

  always_comb begin
    w_slot_end   = (r_presc == P_LAST);
    w_blink_wrap = frame_tick && (r_blink_cnt == B_LAST);
    w_phase_nxt  = enable && (r_phase ^ w_blink_wrap);
  end

  // Message controller; disabling the display aborts any message in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_frame_inc = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (msg_req) begin
            w_state_nxt = S_SYNC;
            w_accept    = 1'b1;
          end
        end
        S_SYNC: begin
          if (frame_tick) w_state_nxt = S_SHOW;
        end
        S_SHOW: begin
          if (frame_tick) begin
            if (r_frame_cnt == M_LAST) w_state_nxt = S_IDLE;
            else                       w_frame_inc = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_msg_active_nxt = (w_state_nxt == S_SHOW);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_frame_cnt <= '0;
      contador    <= 2'd0;
      frame_tick  <= 1'b0;
      blank       <= 1'b1;
      msg_active  <= 1'b0;
      msg_sel     <= 2'd0;
      msg_ack     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      msg_active <= w_msg_active_nxt;
      busy       <= (w_state_nxt != S_IDLE);
      msg_ack    <= w_accept;
      if (w_accept) msg_sel <= msg_code;
      if (r_state == S_SYNC)  r_frame_cnt <= '0;
      else if (w_frame_inc)   r_frame_cnt <= r_frame_cnt + MW'(1);
      // Uses next-cycle phase/message state so blank lines up with msg_active.
      blank <= !enable || (blink_en && w_phase_nxt && !w_msg_active_nxt);
      if (!enable) begin
        r_presc     <= '0;
        contador    <= 2'd0;
        frame_tick  <= 1'b0;
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else begin
        frame_tick <= w_slot_end && (contador == 2'd3);
        if (w_slot_end) begin
          r_presc  <= '0;
          contador <= contador + 2'd1;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
        if (frame_tick) begin
          r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
          r_phase     <= w_phase_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a time-based reference model pushes the
// expected output vector per clock edge; each sampled DUT vector is popped and checked.
module tb_display_scan_ctrl;

  localparam int DIV = 4;
  localparam int BF  = 2;
  localparam int MF  = 3;
  localparam int FRM = 4 * DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       blink_en = 1'b0;
  logic       msg_req = 1'b0;
  logic [1:0] msg_code = 2'd0;
  logic [1:0] contador;
  logic       frame_tick, blank, msg_active, msg_ack, busy;
  logic [1:0] msg_sel;

  display_scan_ctrl #(.DIV(DIV), .BLINK_FRAMES(BF), .MSG_FRAMES(MF)) dut (
    .clock(clock), .reset(reset), .enable(enable), .blink_en(blink_en),
    .msg_req(msg_req), .msg_code(msg_code), .contador(contador),
    .frame_tick(frame_tick), .blank(blank), .msg_active(msg_active),
    .msg_sel(msg_sel), .msg_ack(msg_ack), .busy(busy)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard
  logic [8:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int act_cycles = 0;
  logic count_act = 1'b0;

  // reference model: m_k = enabled edges since reset/disable
  int         m_k = 0;
  int         m_state = 0;
  int         m_shown = 0;
  logic [1:0] e_cont = 2'd0, e_sel = 2'd0;
  logic       e_tick = 1'b0, e_blank = 1'b1, e_act = 1'b0, e_ack = 1'b0, e_busy = 1'b0;

  task automatic model_edge();
    int ph;
    if (reset) begin
      m_k = 0; m_state = 0; m_shown = 0;
      e_cont = 2'd0; e_tick = 1'b0; e_blank = 1'b1; e_act = 1'b0;
      e_sel = 2'd0; e_ack = 1'b0; e_busy = 1'b0;
    end else if (!enable) begin
      m_k = 0; m_state = 0;
      e_cont = 2'd0; e_tick = 1'b0; e_blank = 1'b1; e_act = 1'b0;
      e_ack = 1'b0; e_busy = 1'b0;
    end else begin
      e_ack = 1'b0;
      case (m_state)
        0: if (msg_req) begin m_state = 1; e_sel = msg_code; e_ack = 1'b1; end
        1: if (e_tick) begin m_state = 2; m_shown = 0; end
        default: if (e_tick) begin
          m_shown++;
          if (m_shown == MF) m_state = 0;
        end
      endcase
      m_k++;
      e_cont  = 2'((m_k / DIV) % 4);
      e_tick  = (m_k % FRM) == 0;
      ph      = (((m_k - 1) / FRM) / BF) % 2;
      e_act   = (m_state == 2);
      e_busy  = (m_state != 0);
      e_blank = blink_en && (ph == 1) && !e_act;
    end
  endtask

  // driver: one clock edge, compare at the following falling edge
  task automatic step();
    logic [8:0] got, exp;
    model_edge();
    exp_q.push_back({e_cont, e_tick, e_blank, e_act, e_sel, e_ack, e_busy});
    @(posedge clock);
    @(negedge clock);
    got = {contador, frame_tick, blank, msg_active, msg_sel, msg_ack, busy};
    exp = exp_q.pop_front();
    n_vec++;
    if (count_act && msg_active) act_cycles++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL vec%0d cont/tick/blank/act/sel/ack/busy got=%b expected=%b", n_vec, got, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_val(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s got=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    int ticks;
    bit got_ack;
    // 1. reset then scan
    run(2);
    reset = 1'b0; enable = 1'b1;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame_tick) ticks++;
    end
    check_val("frame_ticks_in_40", ticks, 2);
    // 2. disable mid-slot at contador=2, re-enable
    run(1);
    enable = 1'b0;
    run(2);
    enable = 1'b1;
    run(10);
    // 3. blink on / off / on
    blink_en = 1'b1;
    run(80);
    blink_en = 1'b0;
    run(10);
    blink_en = 1'b1;
    // 4. message request at contador=1
    for (int i = 0; i < 20 && contador != 2'd1; i++) step();
    msg_req = 1'b1; msg_code = 2'd2;
    step();
    check_val("ack_first", int'(msg_ack), 1);
    check_val("sel_first", int'(msg_sel), 2);
    msg_req = 1'b0;
    count_act = 1'b1;
    run(30);
    // 5. request during message, held until acknowledged
    msg_req = 1'b1; msg_code = 2'd1;
    got_ack = 1'b0;
    for (int i = 0; i < 120 && !got_ack; i++) begin
      step();
      got_ack = msg_ack;
    end
    check_val("second_ack_seen", int'(got_ack), 1);
    msg_req = 1'b0;
    count_act = 1'b0;
    check_val("msg_active_cycles", act_cycles, MF * FRM);
    check_val("sel_second", int'(msg_sel), 1);
    // 6. reset during SHOW
    for (int i = 0; i < 40 && !msg_active; i++) step();
    check_val("in_show_before_reset", int'(msg_active), 1);
    run(5);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
